// File: rtl/cpu_clock_ctrl_if.sv
// Front-panel, breakpoint and CPU-clock signals shared by the run-control
// sequencer (slave) and the board/CPU side that drives it (master).
interface cpu_clock_ctrl_if;
  logic        key_speed;
  logic        key_halt;
  logic        key_step;
  logic        bp_en;
  logic [11:0] bp_addr;
  logic [11:0] pc;
  logic        cpu_clk;
  logic        cpu_rise;
  logic        cpu_fall;
  logic        fast;
  logic        halted;
  logic        bp_hit;

  modport master (
    output key_speed, key_halt, key_step, bp_en, bp_addr, pc,
    input  cpu_clk, cpu_rise, cpu_fall, fast, halted, bp_hit
  );

  modport slave (
    input  key_speed, key_halt, key_step, bp_en, bp_addr, pc,
    output cpu_clk, cpu_rise, cpu_fall, fast, halted, bp_hit
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Run-control sequencer: registered CPU clock divider, debounced panel keys,
// RUN/HALT/STEP state machine and a single PC breakpoint.
module cpu_clock_ctrl #(
  parameter int SLOW_HALF  = 20000000,
  parameter int FAST_HALF  = 1000000,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 25
) (
  input  logic            clk,
  input  logic            resetkey,
  cpu_clock_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

  // Key index: 0 = speed, 1 = halt, 2 = step.
  logic [2:0] key_raw;
  logic [2:0] key_evt;

  assign key_raw = {bus.key_step, bus.key_halt, bus.key_speed};

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic             evt;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments on every flop so all registers in a
    // clock edge update from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
      if (!resetkey) begin
        sync_a <= 1'b1;
        sync_b <= 1'b1;
        level  <= 1'b1;
        cnt    <= '0;
        evt    <= 1'b0;
      end else begin
        sync_a <= key_raw[k];
        sync_b <= sync_a;
        evt    <= 1'b0;
        if (sync_b == level) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          level <= sync_b;
          cnt   <= '0;
          evt   <= level;  // only a released->pressed change is an event
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign key_evt[k] = evt;
  end

  state_t           state;
  logic [CNT_W-1:0] half_cnt;
  logic             cpu_clk_q;
  logic             rise_q;
  logic             fall_q;
  logic             fast_q;
  logic             halted_q;
  logic             bp_hit_q;
  logic             half_fast;  // speed governing the half-period in progress
  logic             bp_armed;
  logic             halt_pend;

  logic             speed_evt;
  logic             halt_evt;
  logic             step_evt;
  logic             ticking;
  logic             terminal;
  logic             fall_now;
  logic             bp_match;
  logic             stop_run;
  logic             fast_nxt;

  // NOTE: every always_comb output is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    speed_evt = key_evt[0] && (state != STEP);
    halt_evt  = key_evt[1] && (state != STEP);
    step_evt  = key_evt[2] && (state != STEP);
    ticking   = (state != HALT);
    terminal  = ticking && (half_cnt == (half_fast ? FAST_LAST : SLOW_LAST));
    fall_now  = terminal && cpu_clk_q;
    bp_match  = bus.bp_en && bp_armed && (bus.pc == bus.bp_addr);
    stop_run  = fall_now && (halt_pend || halt_evt || bp_match);
    fast_nxt  = fast_q ^ speed_evt;
  end

  always_ff @(posedge clk) begin
    if (!resetkey) begin
      state     <= RUN;
      half_cnt  <= '0;
      cpu_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      fast_q    <= 1'b0;
      halted_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
      half_fast <= 1'b0;
      bp_armed  <= 1'b1;
      halt_pend <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fast_q <= fast_nxt;

      // A speed change is picked up only at a half-period boundary.
      if (terminal) begin
        cpu_clk_q <= ~cpu_clk_q;
        half_cnt  <= '0;
        rise_q    <= ~cpu_clk_q;
        fall_q    <= cpu_clk_q;
        half_fast <= fast_nxt;
      end else if (ticking) begin
        half_cnt <= half_cnt + CNT_W'(1);
      end else begin
        half_cnt  <= '0;
        half_fast <= fast_nxt;
      end

      if (fall_now && (bus.pc != bus.bp_addr)) bp_armed <= 1'b1;

      case (state)
        RUN: begin
          if (stop_run) begin
            state     <= HALT;
            halted_q  <= 1'b1;
            halt_pend <= 1'b0;
            bp_hit_q  <= bp_match;
          end else if (halt_evt) begin
            halt_pend <= 1'b1;
          end
        end
        HALT: begin
          if (halt_evt) begin
            state    <= RUN;
            halted_q <= 1'b0;
            bp_armed <= 1'b0;
            bp_hit_q <= 1'b0;
          end else if (step_evt) begin
            state    <= STEP;
            halted_q <= 1'b0;
            bp_hit_q <= 1'b0;
          end
        end
        STEP: begin
          if (fall_now) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_clk  = cpu_clk_q;
  assign bus.cpu_rise = rise_q;
  assign bus.cpu_fall = fall_q;
  assign bus.fast     = fast_q;
  assign bus.halted   = halted_q;
  assign bus.bp_hit   = bp_hit_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl with short periods: clock edges are scored against
// an expected-event queue, debounce patterns come from a vector table.
module tb_cpu_clock_ctrl;
  localparam int SLOW = 8;
  localparam int FAST = 2;
  localparam int DEB  = 4;
  // Press event registers 2+DEB edges after the first low sample; the FSM
  // consumes it on the following edge.
  localparam int PRESS_ACT = DEB + 3;

  logic        clk      = 1'b0;
  logic        resetkey = 1'b0;
  logic [2:0]  keys     = 3'b111;
  logic        bp_en    = 1'b0;
  logic [11:0] bp_addr  = 12'h000;
  logic [11:0] pc       = 12'h000;
  bit          pc_auto  = 1'b0;
  bit          sb_on    = 1'b0;
  int          cyc      = 0;
  int          total    = 0;
  int          bad      = 0;

  typedef struct {
    bit rise;
    int cyc;
  } ev_t;
  ev_t sb_q[$];

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          toggles;
  } vec_t;
  vec_t vecs[6];

  cpu_clock_ctrl_if bus ();

  assign bus.key_speed = keys[0];
  assign bus.key_halt  = keys[1];
  assign bus.key_step  = keys[2];
  assign bus.bp_en     = bp_en;
  assign bus.bp_addr   = bp_addr;
  assign bus.pc        = pc;

  cpu_clock_ctrl #(
    .SLOW_HALF (SLOW),
    .FAST_HALF (FAST),
    .DEB_CYCLES(DEB),
    .CNT_W     (8)
  ) dut (
    .clk     (clk),
    .resetkey(resetkey),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input bit rise, input int c);
    ev_t e;
    e.rise = rise;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, output int act);
    int s;
    s = cyc;
    keys = keys & ~mask;
    repeat (6) @(negedge clk);
    keys = 3'b111;
    act = s + PRESS_ACT;
  endtask

  task automatic do_reset(output int r);
    sb_on = 1'b0;
    sb_q.delete();
    @(negedge clk);
    resetkey = 1'b0;
    @(negedge clk);
    r = cyc;
    resetkey = 1'b1;
    check("reset_outs", int'({bus.cpu_clk, bus.cpu_rise, bus.cpu_fall,
                              bus.fast, bus.halted, bus.bp_hit}), 0);
  endtask

  // Pulse monitor / scoreboard consumer, plus the CPU-side pc increment.
  always @(negedge clk) begin : mon
    ev_t e;
    if (sb_on && (bus.cpu_rise || bus.cpu_fall)) begin
      check_b("rise_fall_excl", bus.cpu_rise & bus.cpu_fall, 1'b0);
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse_cycle", cyc, -1);
      end else begin
        e = sb_q.pop_front();
        check_b("sb_kind_rise", bus.cpu_rise, e.rise);
        check("sb_cycle", cyc, e.cyc);
      end
    end
    if (pc_auto && bus.cpu_rise) pc = pc + 12'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2, act, act_h, s0, hl, tog;
    logic prev, exp_fast;
    logic [15:0] p;

    vecs[0] = '{16'h0000, 3, 0};   // too short
    vecs[1] = '{16'h0000, 4, 1};   // exactly long enough
    vecs[2] = '{16'h0002, 8, 1};   // bounce then solid press
    vecs[3] = '{16'h0060, 12, 1};  // short release glitch mid-press
    vecs[4] = '{16'h03E0, 15, 2};  // press, real release, press
    vecs[5] = '{16'h0AAA, 12, 0};  // continuous chatter

    // Reset then idle: rise at +8, fall at +16, period 16.
    do_reset(r);
    sb_on = 1'b1;
    expect_ev(1, r + 8);  expect_ev(0, r + 16);
    expect_ev(1, r + 24); expect_ev(0, r + 32);
    wait_to(r + 7);  check_b("idle_low", bus.cpu_clk, 1'b0);
    wait_to(r + 8);  check_b("idle_high", bus.cpu_clk, 1'b1);
    wait_to(r + 33);
    check_b("idle_fast", bus.fast, 1'b0);
    check_b("idle_halted", bus.halted, 1'b0);
    check("idle_sb_left", sb_q.size(), 0);

    // Speed key with bounce while running: current half stays 8, then 2s.
    do_reset(r);
    sb_on = 1'b1;
    expect_ev(1, r + 8);  expect_ev(0, r + 16);
    expect_ev(1, r + 18); expect_ev(0, r + 20);
    expect_ev(1, r + 22); expect_ev(0, r + 24);
    wait_to(r + 2);
    p = 16'h0002;
    for (int i = 0; i < 8; i++) begin
      keys[0] = p[i];
      @(negedge clk);
    end
    keys[0] = 1'b1;
    wait_to(r + 12); check_b("speed_fast_set", bus.fast, 1'b1);
    wait_to(r + 25);
    check_b("speed_one_toggle", bus.fast, 1'b1);
    check("speed_sb_left", sb_q.size(), 0);
    sb_on = 1'b0;

    // Halt press in the high phase: finishes the high half, then stays low.
    do_reset(r);
    sb_on = 1'b1;
    expect_ev(1, r + 8); expect_ev(0, r + 16);
    wait_to(r + 5);
    press(3'b010, act);
    wait_to(r + 15);
    check_b("halt_high_kept", bus.cpu_clk, 1'b1);
    check_b("halt_not_yet", bus.halted, 1'b0);
    wait_to(r + 16); check_b("halt_at_fall", bus.halted, 1'b1);
    tog = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.cpu_clk !== 1'b0) tog++;
    end
    check("halt_clk_high_cycles", tog, 0);
    press(3'b010, act);
    expect_ev(1, act + SLOW); expect_ev(0, act + 2 * SLOW);
    wait_to(act); check_b("resume_run", bus.halted, 1'b0);
    wait_to(act + 2 * SLOW + 1);
    check("resume_sb_left", sb_q.size(), 0);

    // Halt press in the low phase is held pending until the next fall.
    do_reset(r);
    sb_on = 1'b1;
    expect_ev(1, r + 8); expect_ev(0, r + 16);
    press(3'b010, act);
    wait_to(r + 16); check_b("pend_halt", bus.halted, 1'b1);

    // Three single steps, 50 cycles apart; a halt press inside step 2 is ignored.
    s0 = cyc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_to(s0 + 50);
      s0 = cyc;
      press(3'b100, act);
      expect_ev(1, act + SLOW); expect_ev(0, act + 2 * SLOW);
      check_b("step_pre_halted", bus.halted, 1'b1);
      wait_to(act); check_b("step_running", bus.halted, 1'b0);
      if (i == 1) press(3'b010, act_h);
      wait_to(act + 2 * SLOW - 1); check_b("step_len", bus.halted, 1'b0);
      wait_to(act + 2 * SLOW);     check_b("step_done", bus.halted, 1'b1);
    end
    wait_to(cyc + 20);
    check_b("step_halt_ignored", bus.halted, 1'b1);
    check("step_sb_left", sb_q.size(), 0);

    // Halt and step in the same cycle: halt wins.
    press(3'b110, act);
    expect_ev(1, act + SLOW);
    wait_to(act); check_b("both_keys_run", bus.halted, 1'b0);
    wait_to(act + SLOW + 1);
    check("both_sb_left", sb_q.size(), 0);

    // Breakpoint at 0x005 with pc advancing on each rise.
    bp_en = 1'b1; bp_addr = 12'h005; pc = 12'h000;
    do_reset(r);
    pc_auto = 1'b1;
    wait_to(r + 79); check_b("bp_not_yet", bus.halted, 1'b0);
    wait_to(r + 80);
    check_b("bp_halted", bus.halted, 1'b1);
    check_b("bp_hit_set", bus.bp_hit, 1'b1);
    check("bp_pc", int'(pc), 5);
    wait_to(r + 130);
    check_b("bp_stays_low", bus.cpu_clk, 1'b0);
    pc_auto = 1'b0;
    press(3'b010, act);
    wait_to(act);
    check_b("bp_resume_run", bus.halted, 1'b0);
    check_b("bp_hit_clear", bus.bp_hit, 1'b0);
    wait_to(act + 17); check_b("bp_no_rehit", bus.halted, 1'b0);
    pc_auto = 1'b1;
    wait_to(act + 33);
    check("bp_pc_next", int'(pc), 6);
    check_b("bp_still_run", bus.halted, 1'b0);
    pc = 12'hFFD;
    wait_to(act + 159); check_b("bp_wrap_not_yet", bus.halted, 1'b0);
    wait_to(act + 160);
    check_b("bp_wrap_halted", bus.halted, 1'b1);
    check_b("bp_wrap_hit", bus.bp_hit, 1'b1);
    check("bp_wrap_pc", int'(pc), 5);
    pc_auto = 1'b0; bp_en = 1'b0;

    // Debounce vector table, applied while halted.
    do_reset(r);
    press(3'b010, act);
    wait_to(r + 16); check_b("tbl_halted", bus.halted, 1'b1);
    wait_to(r + 20);
    exp_fast = 1'b0;
    for (int v = 0; v < 6; v++) begin
      p = vecs[v].pat;
      tog = 0;
      prev = bus.fast;
      for (int i = 0; i < vecs[v].len + 12; i++) begin
        keys[0] = (i < vecs[v].len) ? p[i] : 1'b1;
        @(negedge clk);
        if (bus.fast !== prev) begin
          tog++;
          prev = bus.fast;
        end
      end
      check($sformatf("vec%0d_toggles", v), tog, vecs[v].toggles);
      exp_fast = exp_fast ^ vecs[v].toggles[0];
    end
    check_b("tbl_fast", bus.fast, exp_fast);
    check_b("tbl_still_halted", bus.halted, 1'b1);

    // Reset during the high half of a step, on its terminal edge.
    hl = exp_fast ? FAST : SLOW;
    sb_q.delete();
    sb_on = 1'b1;
    press(3'b100, act);
    expect_ev(1, act + hl);
    wait_to(act + 2 * hl - 1);
    check_b("mid_step_high", bus.cpu_clk, 1'b1);
    resetkey = 1'b0;
    @(negedge clk);
    resetkey = 1'b1;
    r2 = cyc;
    check("reset_mid_step", int'({bus.cpu_clk, bus.cpu_rise, bus.cpu_fall,
                                  bus.fast, bus.halted, bus.bp_hit}), 0);
    expect_ev(1, r2 + SLOW); expect_ev(0, r2 + 2 * SLOW);
    wait_to(r2 + 2 * SLOW + 1);
    check("post_reset_sb_left", sb_q.size(), 0);
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
